fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/control stage.
- Owns the fetch PC and issues sequential word requests to a synchronous instruction memory with a fixed one-cycle read latency.
- Buffers the returned {pc, instr} pairs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts branch/jump redirects from next-PC logic and flushes stale work when it does.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2. At least 3 gives one instruction per cycle sustained.
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  32  word-aligned read address; valid when imem_req=1.
- imem_rdata  input  32  read data; valid exactly one cycle after a cycle with imem_req=1.
- redirect_valid  input  1  single-cycle pulse requesting a change of control flow.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr  output  32  instruction word at the FIFO head.
- instr_pc  output  32  address of the instruction at the FIFO head.
- instr_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. Both are fixed decisions.
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO count = 0; read and write pointers = 0.
  - inflight = 0; squash = 0.
  - imem_req = 0, instr_valid = 0.
  - instr = 0, instr_pc = 0.
  - Reset mid-operation discards all buffered and in-flight data. The response arriving in the cycle after reset is dropped.
- Outputs while empty: instr and instr_pc are driven to 0 whenever instr_valid=0.
- Issue rule:
  - imem_req = !rst && !redirect_valid && (count + inflight < DEPTH).
  - count is the registered occupancy. A dequeue in the same cycle does not free a credit until the next cycle.
  - imem_addr = fetch_pc.
- Issue side effects: on an issue, fetch_pc <= fetch_pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0) and inflight <= 1. With no issue, inflight <= 0.
- Response capture:
  - In the cycle after an issue, {addr, imem_rdata} is written at the write pointer, unless squash=1.
  - The captured addr is the address issued one cycle earlier, held in a register.
- Fetch latency: request in cycle N, data in N+1, instr_valid high in N+2. There is no bypass path.
- Dequeue: when instr_valid && instr_ready, the head is popped. A simultaneous write and pop leaves count unchanged.
- Full FIFO: the credit rule guarantees no overflow. A write into a full FIFO is unreachable; an assertion flags it in simulation.
- Redirect (redirect_valid=1 in cycle R), which takes priority over all other activity:
  - FIFO flushed (count=0, pointers=0). Any same-cycle pop is discarded, not counted.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No request issued in cycle R.
  - squash <= inflight, so a response returning in R+1 is dropped.
  - First request to the target in R+1; its instr_valid in R+3.
- Back-to-back redirects: the last one wins. Each redirect restarts the sequence above.
- Output stability: while instr_valid=1 and instr_ready=0, instr and instr_pc hold stable unless a redirect occurs.

Decomposition:
- Package mips_fetch_pkg:
  - ADDR_W=32, INSTR_W=32.
  - DEFAULT_RESET_PC.
  - Typedef fetch_entry_t {pc, instr} (64 bits).
- Sub-module fetch_fifo:
  - Parameterised DEPTH × 64-bit synchronous FIFO.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push and pop.
- The top level holds the PC, the inflight/squash tracking and the credit logic.

Test Plan:
- Reset release, instr_ready=1, memory returns addr as data → imem_addr 0,4,8,… one per cycle. First instr_valid 2 cycles after the first req. instr_pc sequence 0,4,8,… with instr==instr_pc. Steady one instruction per cycle.
- instr_ready=0 for 10 cycles → exactly 4 requests (0,4,8,12), then imem_req=0. instr held at pc 0. On ready=1, drains 0,4,8,12 in order, then requests resume at 16 with no gap or duplicate.
- redirect_valid with redirect_pc=32'h0000_0103, while a request is in flight and FIFO holds 2 → FIFO empty next cycle, in-flight data dropped. Next req addr=32'h100; next instr_pc=32'h100 arrives 3 cycles after the redirect.
- Redirect in the same cycle as instr_valid&&instr_ready → popped entry discarded, not double-counted. Subsequent stream starts at the target with no stale entry.
- RESET_PC=32'hFFFF_FFF8, ready=1 → instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst asserted for 1 cycle while FIFO holds 3 and a request is in flight → all outputs 0 next cycle. No stale instruction ever appears. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared widths, reset default and the buffered entry type for the fetch front end.
package mips_fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;
    logic              full;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; the head is only looked at while count is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(do_push && !do_pop && full));
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch front end: owns the fetch PC, issues one-cycle-latency imem reads under a
// credit limit, and queues the returned {pc, instr} pairs for decode.
module fetch_buffer
    import mips_fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] issued_pc;
    logic              inflight;
    logic              squash;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credits_used;
    fetch_entry_t      push_data;
    fetch_entry_t      head;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Registered occupancy plus the outstanding read; a same-cycle pop frees nothing yet.
    assign credits_used = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue        = !rst && !redirect_valid && (credits_used < (CNT_W+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight && !squash;
    assign push_data   = '{pc: issued_pc, instr: imem_rdata};

    assign instr    = instr_valid ? head.instr : '0;
    assign instr_pc = instr_valid ? head.pc    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            squash    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
            squash   <= inflight;
        end else begin
            inflight <= issue;
            squash   <= 1'b0;
            if (issue) begin
                fetch_pc  <= fetch_pc + ADDR_W'(4);
                issued_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: streaming, back-pressure, redirects, PC wrap and reset.
module tb_fetch_buffer;

    localparam logic [31:0] MEM_XOR = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        instr_valid_w;
    logic [31:0] instr_w;
    logic [31:0] instr_pc_w;
    logic        instr_ready_w;

    int checks   = 0;
    int failures = 0;
    int nreq     = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_rdata     (imem_rdata_w),
        .redirect_valid (redirect_valid_w),
        .redirect_pc    (redirect_pc_w),
        .instr_valid    (instr_valid_w),
        .instr          (instr_w),
        .instr_pc       (instr_pc_w),
        .instr_ready    (instr_ready_w)
    );

    // One-cycle memory: data only follows a real request, otherwise junk.
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? (imem_addr   ^ MEM_XOR) : 32'hDEAD_BEEF;
        imem_rdata_w <= imem_req_w ? (imem_addr_w ^ MEM_XOR) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic obs_req, input logic [31:0] obs_addr,
                           input logic exp_req, input logic [31:0] exp_addr);
        chk({tag, ".req"}, 32'(obs_req), 32'(exp_req));
        if (exp_req) chk({tag, ".addr"}, obs_addr, exp_addr);
    endtask

    task automatic chk_head(input string tag, input logic obs_v, input logic [31:0] obs_instr,
                            input logic [31:0] obs_pc, input logic exp_v, input logic [31:0] exp_pc);
        chk({tag, ".valid"}, 32'(obs_v), 32'(exp_v));
        chk({tag, ".pc"},    obs_pc,     exp_v ? exp_pc : 32'h0);
        chk({tag, ".instr"}, obs_instr,  exp_v ? (exp_pc ^ MEM_XOR) : 32'h0);
    endtask

    initial begin
        rst              = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        instr_ready      = 1'b0;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = 32'h0;
        instr_ready_w    = 1'b1;

        @(negedge clk); #1;
        chk_req("rst0", imem_req, imem_addr, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_req("rst1", imem_req, imem_addr, 1'b0, 32'h0);
        chk_head("rst1", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        chk_head("rst1_w", instr_valid_w, instr_w, instr_pc_w, 1'b0, 32'h0);

        // Streaming from reset with decode always ready
        @(negedge clk); rst = 1'b0; instr_ready = 1'b1; #1;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) begin @(negedge clk); #1; end
            chk_req($sformatf("stream%0d", k), imem_req, imem_addr, 1'b1, 32'(4*k));
            chk_head($sformatf("stream%0d", k), instr_valid, instr, instr_pc, k >= 2, 32'(4*(k-2)));
            if (k < 6) begin
                chk_req($sformatf("wrap%0d", k), imem_req_w, imem_addr_w, 1'b1,
                        32'hFFFF_FFF8 + 32'(4*k));
                chk_head($sformatf("wrap%0d", k), instr_valid_w, instr_w, instr_pc_w, k >= 2,
                         32'hFFFF_FFF8 + 32'(4*(k-2)));
            end
        end

        // Back-pressure from a fresh reset
        @(negedge clk); rst = 1'b1; instr_ready = 1'b0; #1;
        @(negedge clk); rst = 1'b0; #1;
        for (int d = 0; d < 10; d++) begin
            if (d != 0) begin @(negedge clk); #1; end
            chk_req($sformatf("stall%0d", d), imem_req, imem_addr, d <= 3, 32'(4*d));
            chk_head($sformatf("stall%0d", d), instr_valid, instr, instr_pc, d >= 2, 32'h0);
            if (imem_req) nreq++;
        end
        chk("stall.req_count", 32'(nreq), 32'd4);

        @(negedge clk); instr_ready = 1'b1; #1;
        for (int e = 0; e < 6; e++) begin
            if (e != 0) begin @(negedge clk); #1; end
            chk_req($sformatf("drain%0d", e), imem_req, imem_addr, e >= 1, 32'(12 + 4*e));
            chk_head($sformatf("drain%0d", e), instr_valid, instr, instr_pc, 1'b1, 32'(4*e));
        end

        // Redirect with two buffered and one in flight, decode stalled
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; instr_ready = 1'b0; #1;
        chk_req("redir.r0", imem_req, imem_addr, 1'b0, 32'h0);
        chk_head("redir.r0", instr_valid, instr, instr_pc, 1'b1, 32'd24);
        @(negedge clk); redirect_valid = 1'b0; instr_ready = 1'b1; #1;
        chk_req("redir.r1", imem_req, imem_addr, 1'b1, 32'h100);
        chk_head("redir.r1", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_req("redir.r2", imem_req, imem_addr, 1'b1, 32'h104);
        chk_head("redir.r2", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_req("redir.r3", imem_req, imem_addr, 1'b1, 32'h108);
        chk_head("redir.r3", instr_valid, instr, instr_pc, 1'b1, 32'h100);
        @(negedge clk); #1;
        chk_head("redir.r4", instr_valid, instr, instr_pc, 1'b1, 32'h104);

        // Redirect coinciding with a pop
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
        chk_req("rpop.g0", imem_req, imem_addr, 1'b0, 32'h0);
        chk_head("rpop.g0", instr_valid, instr, instr_pc, 1'b1, 32'h108);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk_req("rpop.g1", imem_req, imem_addr, 1'b1, 32'h200);
        chk_head("rpop.g1", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_head("rpop.g2", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_head("rpop.g3", instr_valid, instr, instr_pc, 1'b1, 32'h200);
        @(negedge clk); #1;
        chk_head("rpop.g4", instr_valid, instr, instr_pc, 1'b1, 32'h204);

        // Back-to-back redirects: the second target wins
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; #1;
        chk_req("b2b.h0", imem_req, imem_addr, 1'b0, 32'h0);
        @(negedge clk); redirect_pc = 32'h0000_0400; #1;
        chk_req("b2b.h1", imem_req, imem_addr, 1'b0, 32'h0);
        chk_head("b2b.h1", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk_req("b2b.h2", imem_req, imem_addr, 1'b1, 32'h400);
        chk_head("b2b.h2", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_head("b2b.h3", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_head("b2b.h4", instr_valid, instr, instr_pc, 1'b1, 32'h400);
        @(negedge clk); #1;
        chk_head("b2b.h5", instr_valid, instr, instr_pc, 1'b1, 32'h404);

        // Fill to three buffered plus one in flight, then pulse reset
        @(negedge clk); instr_ready = 1'b0; #1;
        chk_req("fill.k0", imem_req, imem_addr, 1'b1, 32'h410);
        chk_head("fill.k0", instr_valid, instr, instr_pc, 1'b1, 32'h408);
        @(negedge clk); #1;
        chk_req("fill.k1", imem_req, imem_addr, 1'b1, 32'h414);
        @(negedge clk); #1;
        chk_req("fill.k2", imem_req, imem_addr, 1'b0, 32'h0);
        chk_head("fill.k2", instr_valid, instr, instr_pc, 1'b1, 32'h408);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; instr_ready = 1'b1; #1;
        chk_req("rstmid.k3", imem_req, imem_addr, 1'b1, 32'h0);
        chk_head("rstmid.k3", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_req("rstmid.k4", imem_req, imem_addr, 1'b1, 32'h4);
        chk_head("rstmid.k4", instr_valid, instr, instr_pc, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_head("rstmid.k5", instr_valid, instr, instr_pc, 1'b1, 32'h0);
        @(negedge clk); #1;
        chk_head("rstmid.k6", instr_valid, instr, instr_pc, 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
